// File: rtl/bus_share_arb.sv
// Round-robin arbiter sharing one registered W-bit bus among N requesters, with an idle gap per hand-over.
// Defining BUS_SHARE_ARB_TIMEOUT_EN adds an ownership timeout that preempts the owner when others wait.
module bus_share_arb #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rstb,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   bus,
    output logic           bus_valid,
    output logic           preempt
);
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] arb_idx, scan_idx;
    logic          arb_hit;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [W-1:0]  bus_q, bus_d, own_data;
    logic          bus_valid_q, bus_valid_d;
    logic          req_own;

    if (N < 2 || N > 16 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_cfg
        $error("bus_share_arb: parameter out of range");
    end

`ifdef BUS_SHARE_ARB_TIMEOUT_EN
    localparam int unsigned CW = 8;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          preempt_q, preempt_d;
    logic          others;
    logic          expire;

    assign others = |(req & ~gnt_q);
    assign expire = (cnt_q == CW'(TIMEOUT - 1));
`endif

    // First requester at or above ptr, wrapping modulo N
    always_comb begin : arb_scan
        arb_hit  = 1'b0;
        arb_idx  = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            scan_idx = PW'((32'(ptr_q) + i) % N);
            if (!arb_hit && req[scan_idx]) begin
                arb_hit = 1'b1;
                arb_idx = scan_idx;
            end
        end
    end

    always_comb begin : own_mux
        own_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (owner_q == PW'(i)) begin
                own_data = data_in[i*W +: W];
            end
        end
    end

    assign req_own = req[owner_q];

    always_comb begin : fsm_next
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        bus_d       = bus_q;
        bus_valid_d = 1'b0;
`ifdef BUS_SHARE_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        preempt_d   = 1'b0;
`endif
        unique case (state_q)
            OWN: begin
                bus_d       = own_data;
                bus_valid_d = 1'b1;
                if (!req_own) begin
                    state_d = GAP;
                    gnt_d   = '0;
                end
`ifdef BUS_SHARE_ARB_TIMEOUT_EN
                else if (expire && others) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    preempt_d = 1'b1;
                end else if (!expire) begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            default: begin
                // IDLE and GAP both arbitrate; GAP falls back to IDLE when nobody asks
                if (arb_hit) begin
                    state_d = OWN;
                    owner_d = arb_idx;
                    ptr_d   = (arb_idx == PW'(N - 1)) ? '0 : arb_idx + PW'(1);
                    gnt_d   = N'(1) << arb_idx;
`ifdef BUS_SHARE_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin : regs
        if (!rstb) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            bus_q       <= '0;
            bus_valid_q <= 1'b0;
`ifdef BUS_SHARE_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            preempt_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            bus_q       <= bus_d;
            bus_valid_q <= bus_valid_d;
`ifdef BUS_SHARE_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            preempt_q   <= preempt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign bus       = bus_q;
    assign bus_valid = bus_valid_q;
`ifdef BUS_SHARE_ARB_TIMEOUT_EN
    assign preempt   = preempt_q;
`else
    assign preempt   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_share_arb.sv
// Scoreboard bench for bus_share_arb: stimulus queues expected post-edge outputs, a monitor compares them.
module tb_bus_share_arb;
    localparam int unsigned N       = 4;
    localparam int unsigned W       = 8;
    localparam int unsigned TIMEOUT = 4;

    logic           clk = 1'b0;
    logic           rstb;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   gnt;
    logic [W-1:0]   bus;
    logic           bus_valid;
    logic           preempt;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [7:0] bus;
        logic       bv;
        logic       pre;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bus_share_arb #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .req       (req),
        .data_in   (data_in),
        .gnt       (gnt),
        .bus       (bus),
        .bus_valid (bus_valid),
        .preempt   (preempt)
    );

    // Monitor: one expected entry per clock edge, compared mid-cycle
    always @(negedge clk) begin
        if (rstb && sb.size() > 0) begin
            mon_e = sb.pop_front();
            total++;
            if ({gnt, bus, bus_valid, preempt} !== {mon_e.gnt, mon_e.bus, mon_e.bv, mon_e.pre}) begin
                bad++;
                $display("FAIL %s: got gnt=%b bus=%h bv=%b pre=%b, want gnt=%b bus=%h bv=%b pre=%b",
                         mon_e.tag, gnt, bus, bus_valid, preempt,
                         mon_e.gnt, mon_e.bus, mon_e.bv, mon_e.pre);
            end
        end
    end

    task automatic cyc(input logic [3:0] r, input logic [3:0] g, input logic [7:0] b,
                       input logic v, input logic p, input string tag);
        exp_t e;
        req = r;
        @(posedge clk);
        #1;
        e.tag = tag;
        e.gnt = g;
        e.bus = b;
        e.bv  = v;
        e.pre = p;
        sb.push_back(e);
    endtask

    task automatic check_now(input string tag, input logic [3:0] g, input logic [7:0] b,
                             input logic v, input logic p);
        total++;
        if ({gnt, bus, bus_valid, preempt} !== {g, b, v, p}) begin
            bad++;
            $display("FAIL %s: got gnt=%b bus=%h bv=%b pre=%b, want gnt=%b bus=%h bv=%b pre=%b",
                     tag, gnt, bus, bus_valid, preempt, g, b, v, p);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstb    = 1'b0;
        req     = '0;
        data_in = {8'h44, 8'h33, 8'h22, 8'hA5};
        repeat (3) @(negedge clk);
        #1 rstb = 1'b1;
        check_now("reset_state", 4'b0000, 8'h00, 1'b0, 1'b0);

        // Latency from IDLE, then release through GAP to IDLE (ptr ends at 1)
        cyc(4'b0001, 4'b0001, 8'h00, 1'b0, 1'b0, "lat_gnt");
        cyc(4'b0001, 4'b0001, 8'hA5, 1'b1, 1'b0, "lat_bus");
        cyc(4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0, "lat_rel_gap");
        cyc(4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0, "lat_rel_idle");

        // Requester 1 owns the bus, then an asynchronous reset mid-ownership
        cyc(4'b0010, 4'b0010, 8'hA5, 1'b0, 1'b0, "r1_gnt");
        cyc(4'b0010, 4'b0010, 8'h22, 1'b1, 1'b0, "r1_bus");
        @(negedge clk);
        #1 rstb = 1'b0;
        #1 check_now("async_reset", 4'b0000, 8'h00, 1'b0, 1'b0);
        req = '0;
        @(negedge clk);
        #1 rstb = 1'b1;

        // All four requesting, each owner releases after 3 cycles: order 0,1,2,3,0
        cyc(4'b1111, 4'b0001, 8'h00, 1'b0, 1'b0, "rr0_gnt");
        cyc(4'b1111, 4'b0001, 8'hA5, 1'b1, 1'b0, "rr0_own");
        cyc(4'b1111, 4'b0001, 8'hA5, 1'b1, 1'b0, "rr0_own");
        cyc(4'b1110, 4'b0000, 8'hA5, 1'b1, 1'b0, "rr0_gap");
        cyc(4'b1111, 4'b0010, 8'hA5, 1'b0, 1'b0, "rr1_gnt");
        cyc(4'b1111, 4'b0010, 8'h22, 1'b1, 1'b0, "rr1_own");
        cyc(4'b1111, 4'b0010, 8'h22, 1'b1, 1'b0, "rr1_own");
        cyc(4'b1101, 4'b0000, 8'h22, 1'b1, 1'b0, "rr1_gap");
        cyc(4'b1111, 4'b0100, 8'h22, 1'b0, 1'b0, "rr2_gnt");
        cyc(4'b1111, 4'b0100, 8'h33, 1'b1, 1'b0, "rr2_own");
        cyc(4'b1111, 4'b0100, 8'h33, 1'b1, 1'b0, "rr2_own");
        cyc(4'b1011, 4'b0000, 8'h33, 1'b1, 1'b0, "rr2_gap");
        cyc(4'b1111, 4'b1000, 8'h33, 1'b0, 1'b0, "rr3_gnt");
        cyc(4'b1111, 4'b1000, 8'h44, 1'b1, 1'b0, "rr3_own");
        cyc(4'b1111, 4'b1000, 8'h44, 1'b1, 1'b0, "rr3_own");
        cyc(4'b0111, 4'b0000, 8'h44, 1'b1, 1'b0, "rr3_gap");
        cyc(4'b1111, 4'b0001, 8'h44, 1'b0, 1'b0, "rr0b_gnt");
        cyc(4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0, "rr0b_gap");
        cyc(4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0, "rr_idle");

        // Move ptr to 3, then req=1001: 3 first, 0 after wrap
        cyc(4'b0100, 4'b0100, 8'hA5, 1'b0, 1'b0, "wp_r2_gnt");
        cyc(4'b0000, 4'b0000, 8'h33, 1'b1, 1'b0, "wp_r2_gap");
        cyc(4'b0000, 4'b0000, 8'h33, 1'b0, 1'b0, "wp_idle");
        cyc(4'b1001, 4'b1000, 8'h33, 1'b0, 1'b0, "wrap_r3_gnt");
        cyc(4'b1001, 4'b1000, 8'h44, 1'b1, 1'b0, "wrap_r3_own");
        cyc(4'b0001, 4'b0000, 8'h44, 1'b1, 1'b0, "wrap_gap");
        cyc(4'b0001, 4'b0001, 8'h44, 1'b0, 1'b0, "wrap_r0_gnt");
        cyc(4'b0001, 4'b0001, 8'hA5, 1'b1, 1'b0, "wrap_r0_own");
        cyc(4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0, "wrap_r0_gap");
        cyc(4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0, "wrap_idle");

        // Sole requester 2 drops req for one cycle and re-raises: GAP then straight back to OWN
        cyc(4'b0100, 4'b0100, 8'hA5, 1'b0, 1'b0, "solo_gnt");
        cyc(4'b0100, 4'b0100, 8'h33, 1'b1, 1'b0, "solo_own");
        cyc(4'b0000, 4'b0000, 8'h33, 1'b1, 1'b0, "solo_gap");
        cyc(4'b0100, 4'b0100, 8'h33, 1'b0, 1'b0, "solo_regnt");
        cyc(4'b0100, 4'b0100, 8'h33, 1'b1, 1'b0, "solo_reown");
        cyc(4'b0000, 4'b0000, 8'h33, 1'b1, 1'b0, "solo_gap2");
        cyc(4'b0000, 4'b0000, 8'h33, 1'b0, 1'b0, "solo_idle");

        // Requester 0 holds, requester 1 waits (ptr=3, so 0 wins first)
        cyc(4'b0011, 4'b0001, 8'h33, 1'b0, 1'b0, "to_gnt0");
        cyc(4'b0011, 4'b0001, 8'hA5, 1'b1, 1'b0, "to_own0");
        cyc(4'b0011, 4'b0001, 8'hA5, 1'b1, 1'b0, "to_own0");
        cyc(4'b0011, 4'b0001, 8'hA5, 1'b1, 1'b0, "to_own0");
`ifdef BUS_SHARE_ARB_TIMEOUT_EN
        cyc(4'b0011, 4'b0000, 8'hA5, 1'b1, 1'b1, "to_preempt");
        cyc(4'b0011, 4'b0010, 8'hA5, 1'b0, 1'b0, "to_gnt1");
        cyc(4'b0011, 4'b0010, 8'h22, 1'b1, 1'b0, "to_own1");
        cyc(4'b0000, 4'b0000, 8'h22, 1'b1, 1'b0, "to_gap");
        cyc(4'b0000, 4'b0000, 8'h22, 1'b0, 1'b0, "to_idle");
`else
        cyc(4'b0011, 4'b0001, 8'hA5, 1'b1, 1'b0, "noto_hold");
        cyc(4'b0011, 4'b0001, 8'hA5, 1'b1, 1'b0, "noto_hold");
        cyc(4'b0011, 4'b0001, 8'hA5, 1'b1, 1'b0, "noto_hold");
        cyc(4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0, "noto_gap");
        cyc(4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0, "noto_idle");
`endif

        for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
